// File: rtl/clock_pkg.sv
// Shared definitions for the digital clock front end: mode encoding,
// timebase ratios and the counter width helper.
package clock_pkg;

  typedef enum logic [1:0] {
    MODE_RUN      = 2'b00,
    MODE_SET_SEC  = 2'b01,
    MODE_SET_MIN  = 2'b10,
    MODE_SET_HOUR = 2'b11
  } mode_t;

  // Base tick rate derived from the system clock.
  localparam int TICK_HZ = 10;

  // Ticks per half period of each output square wave.
  localparam int DIV_5HZ_TICKS = 1;
  localparam int DIV_1HZ_TICKS = 5;

  // Bits needed to count 0..n-1; never less than one bit.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One push-button: two-flop synchroniser, stability counter and a
// one-cycle press pulse on each accepted release->press change.
module btn_debounce
  import clock_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
  output logic level_n,
  output logic press
);

  localparam int CW = cnt_width(DEBOUNCE_CYC);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

  logic          sync1;
  logic          sync2;
  logic          level_d1;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= btn_n;
      sync2 <= sync1;
    end
  end

  // Any sample that agrees with the accepted level restarts the count,
  // so a glitch must persist DEBOUNCE_CYC samples to be taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_n <= 1'b1;
      cnt     <= '0;
    end else if (sync2 == level_n) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      level_n <= sync2;
      cnt     <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_d1 <= 1'b1;
    end else begin
      level_d1 <= level_n;
    end
  end

  assign press = level_d1 & ~level_n;

endmodule

// File: rtl/clock_ctrl.sv
// Clock front end: 10 Hz tick prescaler, 5 Hz and 1 Hz square waves,
// debounced buttons, mode FSM and adjust levels aligned to ena_5hz.
module clock_ctrl
  import clock_pkg::*;
#(
  parameter int CLK_HZ       = 50_000_000,
  parameter int DEBOUNCE_CYC = 1_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_mode_n,
  input  logic       btn_up_n,
  input  logic       btn_dw_n,
  output logic [1:0] select_mode,
  output logic       ena,
  output logic       ena_5hz,
  output logic       ena_up,
  output logic       ena_dw
);

  localparam int PRE_CNT = CLK_HZ / TICK_HZ;
  localparam int PW      = cnt_width(PRE_CNT);
  localparam int TW      = cnt_width(DIV_1HZ_TICKS);
  localparam logic [PW-1:0] PRE_LAST = PW'(PRE_CNT - 1);
  localparam logic [TW-1:0] TC_LAST  = TW'(DIV_1HZ_TICKS - 1);

  logic          mode_level_n;
  logic          mode_press;
  logic          up_level_n;
  logic          dw_level_n;
  logic          unused_up_press;
  logic          unused_dw_press;
  mode_t         mode_q;
  mode_t         mode_d;
  logic          run_entry;
  logic [PW-1:0] pre;
  logic [TW-1:0] tc;
  logic          tick;
  logic          up_req;
  logic          dw_req;

  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_mode (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_n   (btn_mode_n),
    .level_n (mode_level_n),
    .press   (mode_press)
  );

  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_up (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_n   (btn_up_n),
    .level_n (up_level_n),
    .press   (unused_up_press)
  );

  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_dw (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_n   (btn_dw_n),
    .level_n (dw_level_n),
    .press   (unused_dw_press)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= MODE_RUN;
    end else begin
      mode_q <= mode_d;
    end
  end

  always_comb begin
    mode_d = mode_q;
    if (mode_press) begin
      case (mode_q)
        MODE_RUN:      mode_d = MODE_SET_SEC;
        MODE_SET_SEC:  mode_d = MODE_SET_MIN;
        MODE_SET_MIN:  mode_d = MODE_SET_HOUR;
        default:       mode_d = MODE_RUN;
      endcase
    end
  end

  assign select_mode = mode_q;
  assign run_entry   = mode_press && (mode_q == MODE_SET_HOUR);
  assign tick        = (pre == PRE_LAST);

  // Returning to RUN restarts the whole timebase so the first second
  // after editing is a full one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre     <= '0;
      tc      <= '0;
      ena     <= 1'b0;
      ena_5hz <= 1'b0;
    end else if (run_entry) begin
      pre     <= '0;
      tc      <= '0;
      ena     <= 1'b0;
      ena_5hz <= 1'b0;
    end else begin
      pre <= tick ? '0 : pre + PW'(1);
      if (tick) begin
        ena_5hz <= ~ena_5hz;
        if (tc == TC_LAST) begin
          tc  <= '0;
          ena <= ~ena;
        end else begin
          tc <= tc + TW'(1);
        end
      end
    end
  end

  assign up_req = !up_level_n && dw_level_n && (mode_q != MODE_RUN);
  assign dw_req = !dw_level_n && up_level_n && (mode_q != MODE_RUN);

  // Loading only as ena_5hz falls keeps the levels steady around each rise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ena_up <= 1'b1;
      ena_dw <= 1'b1;
    end else if (run_entry) begin
      ena_up <= 1'b1;
      ena_dw <= 1'b1;
    end else if (tick && ena_5hz) begin
      ena_up <= ~up_req;
      ena_dw <= ~dw_req;
    end
  end

endmodule

// File: tb/tb_clock_ctrl.sv
// Bench for clock_ctrl with a fast timebase (tick every 10 cycles) and a
// short debounce; outputs are predicted from edge arithmetic and event lists.
module tb_clock_ctrl;
  import clock_pkg::*;

  localparam int CLK_HZ   = 100;
  localparam int DEB      = 4;
  localparam int TICK_CYC = CLK_HZ / 10;
  localparam logic [5:0] RESET_VEC = 6'b00_0_0_1_1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] raw = 3'b111;
  logic [1:0] select_mode;
  logic       ena;
  logic       ena_5hz;
  logic       ena_up;
  logic       ena_dw;

  clock_ctrl #(.CLK_HZ(CLK_HZ), .DEBOUNCE_CYC(DEB)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn_mode_n  (raw[0]),
    .btn_up_n    (raw[1]),
    .btn_dw_n    (raw[2]),
    .select_mode (select_mode),
    .ena         (ena),
    .ena_5hz     (ena_5hz),
    .ena_up      (ena_up),
    .ena_dw      (ena_dw)
  );

  always #5 clk = ~clk;

  // Reference model: debounced changes are scheduled by the drivers as
  // (edge, button, level) events; square waves follow from edges since t0.
  typedef struct {
    int   at_edge;
    int   btn;
    logic val;
  } ev_t;

  ev_t        ev_q[$];
  logic [1:0] exp_q[$];
  logic [2:0] last_sched = 3'b111;
  int         cyc = 0;
  int         t0 = 0;
  int         ev_rd = 0;
  logic [1:0] m_mode = 2'b00;
  logic [2:0] m_db = 3'b111;
  logic       m_up = 1'b1;
  logic       m_dw = 1'b1;
  bit         adv_pend = 1'b0;
  int         n_cmp = 0;
  int         n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge rst_n) begin
    int   e;
    int   n;
    logic up_req;
    logic dw_req;
    if (!rst_n) begin
      m_mode   = 2'b00;
      m_db     = 3'b111;
      m_up     = 1'b1;
      m_dw     = 1'b1;
      adv_pend = 1'b0;
      ev_rd    = ev_q.size();
      t0       = cyc + 1;
    end else begin
      e = cyc + 1;
      n = e - t0;
      up_req = !m_db[1] && m_db[2] && (m_mode != 2'b00);
      dw_req = !m_db[2] && m_db[1] && (m_mode != 2'b00);
      if (adv_pend && m_mode == 2'b11) begin
        m_mode = 2'b00;
        t0     = e;
        m_up   = 1'b1;
        m_dw   = 1'b1;
      end else begin
        if (adv_pend) m_mode = m_mode + 2'd1;
        if (n > 0 && n % (2 * TICK_CYC) == 0) begin
          m_up = !up_req;
          m_dw = !dw_req;
        end
      end
      adv_pend = 1'b0;
      while (ev_rd < ev_q.size() && ev_q[ev_rd].at_edge <= e) begin
        m_db[ev_q[ev_rd].btn] = ev_q[ev_rd].val;
        if (ev_q[ev_rd].btn == 0 && !ev_q[ev_rd].val) adv_pend = 1'b1;
        ev_rd++;
      end
    end
  end

  function automatic logic [5:0] model_vec();
    int   n;
    logic e1;
    logic e5;
    n  = cyc - t0;
    if (n < 0) n = 0;
    e1 = ((n / (5 * TICK_CYC)) % 2) == 1;
    e5 = ((n / TICK_CYC) % 2) == 1;
    return {m_mode, e1, e5, m_up, m_dw};
  endfunction

  function automatic logic [5:0] dut_vec();
    return {select_mode, ena, ena_5hz, ena_up, ena_dw};
  endfunction

  // First ena_5hz falling edge strictly after edge d.
  function automatic int next_fall(input int d);
    int k;
    k = (d - t0) / (2 * TICK_CYC) + 1;
    return t0 + k * 2 * TICK_CYC;
  endfunction

  // Called at a negedge; a stable level is promised to last > DEB cycles.
  task automatic drive_btn(input int b, input logic v, input bit stable);
    ev_t ev;
    raw[b] = v;
    if (stable && v !== last_sched[b]) begin
      ev.at_edge = cyc + 2 + DEB;
      ev.btn     = b;
      ev.val     = v;
      ev_q.push_back(ev);
      last_sched[b] = v;
    end
  endtask

  task automatic press_mode();
    @(negedge clk);
    drive_btn(0, 1'b0, 1'b1);
    repeat (DEB + 8) @(negedge clk);
    drive_btn(0, 1'b1, 1'b1);
    repeat (DEB + 8) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    raw   = 3'b111;
    repeat (3) begin
      @(negedge clk);
      n_cmp++;
      if (dut_vec() !== RESET_VEC) begin
        n_bad++;
        $display("FAIL reset_state: got %b want %b", dut_vec(), RESET_VEC);
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_timebase(input string tag);
    int   rel;
    int   len;
    int   r5;
    int   f5;
    int   r1;
    int   f1;
    logic p5;
    logic p1;
    rel = cyc;
    len = 220 + $urandom_range(0, 40);
    r5 = -1; f5 = -1; r1 = -1; f1 = -1; p5 = 1'b0; p1 = 1'b0;
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      n_cmp++;
      if (dut_vec() !== model_vec()) begin
        n_bad++;
        $display("FAIL %s_track: cyc %0d got %b want %b", tag, cyc, dut_vec(), model_vec());
      end
      if (ena_5hz && !p5 && r5 < 0) r5 = cyc - rel;
      if (!ena_5hz && p5 && f5 < 0) f5 = cyc - rel;
      if (ena && !p1 && r1 < 0) r1 = cyc - rel;
      if (!ena && p1 && f1 < 0) f1 = cyc - rel;
      p5 = ena_5hz;
      p1 = ena;
    end
    n_cmp += 4;
    if (r5 !== TICK_CYC) begin
      n_bad++; $display("FAIL %s_5hz_rise: got %0d want %0d", tag, r5, TICK_CYC);
    end
    if (f5 !== 2 * TICK_CYC) begin
      n_bad++; $display("FAIL %s_5hz_fall: got %0d want %0d", tag, f5, 2 * TICK_CYC);
    end
    if (r1 !== 5 * TICK_CYC) begin
      n_bad++; $display("FAIL %s_1hz_rise: got %0d want %0d", tag, r1, 5 * TICK_CYC);
    end
    if (f1 !== 10 * TICK_CYC) begin
      n_bad++; $display("FAIL %s_1hz_fall: got %0d want %0d", tag, f1, 10 * TICK_CYC);
    end
  endtask

  task automatic test_mode();
    int         c;
    int         hold;
    int         entry;
    int         r1;
    logic       p1;
    logic [1:0] prev_mode;
    logic [1:0] want;
    // bounce shorter than the debounce window
    @(negedge clk);
    drive_btn(0, 1'b0, 1'b0);
    repeat ($urandom_range(1, DEB - 1)) @(negedge clk);
    drive_btn(0, 1'b1, 1'b0);
    repeat (12) begin
      @(negedge clk);
      n_cmp++;
      if (select_mode !== 2'b00 || dut_vec() !== model_vec()) begin
        n_bad++;
        $display("FAIL bounce_ignored: got %b want %b", dut_vec(), model_vec());
      end
    end
    exp_q = '{2'b01, 2'b10, 2'b11, 2'b00};
    prev_mode = 2'b00;
    entry = -1; r1 = -1; p1 = ena;
    for (int p = 0; p < 4; p++) begin
      @(negedge clk);
      drive_btn(0, 1'b0, 1'b1);
      c    = cyc;
      hold = $urandom_range(12, 30);
      for (int i = 0; i < hold + ((p == 3) ? 90 : 12); i++) begin
        @(negedge clk);
        if (i == hold) drive_btn(0, 1'b1, 1'b1);
        n_cmp++;
        if (dut_vec() !== model_vec()) begin
          n_bad++;
          $display("FAIL mode_track: cyc %0d got %b want %b", cyc, dut_vec(), model_vec());
        end
        if (cyc == c + 2 + DEB) begin
          n_cmp++;
          if (select_mode !== prev_mode) begin
            n_bad++; $display("FAIL mode_early: got %b want %b", select_mode, prev_mode);
          end
        end
        if (cyc == c + 3 + DEB) begin
          want = exp_q.pop_front();
          n_cmp++;
          if (select_mode !== want) begin
            n_bad++; $display("FAIL mode_step: got %b want %b", select_mode, want);
          end
          prev_mode = want;
          if (p == 3) begin
            entry = cyc;
            n_cmp++;
            if (ena !== 1'b0 || ena_5hz !== 1'b0) begin
              n_bad++; $display("FAIL run_entry_clear: got ena=%b ena_5hz=%b want 0 0", ena, ena_5hz);
            end
          end
        end
        if (entry >= 0 && ena && !p1 && r1 < 0) r1 = cyc - entry;
        p1 = ena;
      end
    end
    n_cmp++;
    if (r1 !== 5 * TICK_CYC) begin
      n_bad++; $display("FAIL run_entry_1hz: got %0d want %0d", r1, 5 * TICK_CYC);
    end
  endtask

  task automatic test_up_hold();
    int   hold;
    int   d;
    int   rup;
    bit   saw_low;
    logic p5;
    logic pu;
    repeat (3) press_mode();
    @(negedge clk);
    drive_btn(1, 1'b0, 1'b1);
    hold = $urandom_range(180, 220);
    saw_low = 1'b0; rup = -1; d = -1;
    p5 = ena_5hz; pu = ena_up;
    for (int i = 0; i < hold + 60; i++) begin
      @(negedge clk);
      if (i == hold) begin
        drive_btn(1, 1'b1, 1'b1);
        d = cyc + 2 + DEB;
      end
      n_cmp++;
      if (dut_vec() !== model_vec()) begin
        n_bad++;
        $display("FAIL up_track: cyc %0d got %b want %b", cyc, dut_vec(), model_vec());
      end
      if (ena_up !== pu) begin
        n_cmp++;
        if (!(p5 && !ena_5hz)) begin
          n_bad++; $display("FAIL up_align: cyc %0d ena_5hz %b->%b want 1->0", cyc, p5, ena_5hz);
        end
      end
      if (!ena_up) saw_low = 1'b1;
      if (d >= 0 && ena_up && !pu && rup < 0) rup = cyc;
      p5 = ena_5hz;
      pu = ena_up;
    end
    n_cmp += 2;
    if (!saw_low) begin
      n_bad++; $display("FAIL up_seen: got ena_up never 0 want 0 while held");
    end
    if (rup !== next_fall(d)) begin
      n_bad++; $display("FAIL up_release: got %0d want %0d", rup, next_fall(d));
    end
  endtask

  task automatic test_both();
    int   hold;
    int   d;
    int   rdw;
    bit   both_bad;
    logic pd;
    repeat (3) press_mode();
    @(negedge clk);
    drive_btn(1, 1'b0, 1'b1);
    drive_btn(2, 1'b0, 1'b1);
    hold = $urandom_range(80, 120);
    both_bad = 1'b0; rdw = -1; d = -1; pd = ena_dw;
    for (int i = 0; i < hold + 110; i++) begin
      @(negedge clk);
      if (i == hold) begin
        drive_btn(1, 1'b1, 1'b1);
        d = cyc + 2 + DEB;
      end
      if (i == hold + 60) drive_btn(2, 1'b1, 1'b1);
      n_cmp++;
      if (dut_vec() !== model_vec()) begin
        n_bad++;
        $display("FAIL both_track: cyc %0d got %b want %b", cyc, dut_vec(), model_vec());
      end
      if (i < hold && (!ena_up || !ena_dw)) both_bad = 1'b1;
      if (d >= 0 && !ena_dw && pd && rdw < 0) rdw = cyc;
      pd = ena_dw;
    end
    n_cmp += 2;
    if (both_bad) begin
      n_bad++; $display("FAIL both_held: got an active adjust level want both 1");
    end
    if (rdw !== next_fall(d)) begin
      n_bad++; $display("FAIL dw_after_up_release: got %0d want %0d", rdw, next_fall(d));
    end
  endtask

  task automatic test_run_hold();
    int   a;
    int   rdw;
    bit   run_bad;
    logic pd;
    repeat (2) press_mode();
    @(negedge clk);
    drive_btn(2, 1'b0, 1'b1);
    run_bad = 1'b0;
    repeat (60) begin
      @(negedge clk);
      n_cmp++;
      if (dut_vec() !== model_vec()) begin
        n_bad++;
        $display("FAIL run_hold_track: cyc %0d got %b want %b", cyc, dut_vec(), model_vec());
      end
      if (!ena_dw) run_bad = 1'b1;
    end
    n_cmp++;
    if (run_bad) begin
      n_bad++; $display("FAIL run_no_adjust: got ena_dw 0 want 1");
    end
    @(negedge clk);
    drive_btn(0, 1'b0, 1'b1);
    a = cyc + 3 + DEB;
    rdw = -1; pd = ena_dw;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (i == DEB + 8) drive_btn(0, 1'b1, 1'b1);
      if (i == 70) drive_btn(2, 1'b1, 1'b1);
      n_cmp++;
      if (dut_vec() !== model_vec()) begin
        n_bad++;
        $display("FAIL set_hold_track: cyc %0d got %b want %b", cyc, dut_vec(), model_vec());
      end
      if (!ena_dw && pd && rdw < 0) rdw = cyc;
      pd = ena_dw;
    end
    n_cmp++;
    if (rdw !== next_fall(a)) begin
      n_bad++; $display("FAIL dw_after_advance: got %0d want %0d", rdw, next_fall(a));
    end
  endtask

  task automatic test_reset_mid();
    int waited;
    repeat (2) press_mode();
    @(negedge clk);
    drive_btn(1, 1'b0, 1'b1);
    waited = 0;
    while (m_up !== 1'b0 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    n_cmp++;
    if (ena_up !== 1'b0 || select_mode !== 2'b11) begin
      n_bad++;
      $display("FAIL pre_reset: got mode %b ena_up %b want 11 0", select_mode, ena_up);
    end
    repeat ($urandom_range(0, 7)) @(negedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    last_sched = 3'b111;
    #1;
    n_cmp++;
    if (dut_vec() !== RESET_VEC) begin
      n_bad++; $display("FAIL reset_async: got %b want %b", dut_vec(), RESET_VEC);
    end
    repeat (3) begin
      @(negedge clk);
      n_cmp++;
      if (dut_vec() !== RESET_VEC) begin
        n_bad++; $display("FAIL reset_hold: got %b want %b", dut_vec(), RESET_VEC);
      end
    end
    raw   = 3'b111;
    rst_n = 1'b1;
    test_timebase("rerun");
  endtask

  initial begin
    test_reset();
    test_timebase("boot");
    test_mode();
    test_up_hold();
    test_both();
    test_run_hold();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
